// File: rtl/gps_spi_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | gps_spi_rx : SPI mode-0 slave receiver for packed GPS I/Q bytes, with a  |
// | first-word-fall-through byte FIFO.          Revision 1.0                 |
// +--------------------------------------------------------------------------+
module gps_spi_rx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       MCU_CLK_25_000,
  input  logic       RESET,
  input  logic       SPI_SCK,
  input  logic       SPI_SS,
  input  logic       SPI_MOSI,
  input  logic       RX_READY,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic [3:0] SAMPLE,
  output logic       FRAME_ACTIVE,
  output logic [7:0] FRAME_BYTES,
  output logic       OVERRUN,
  output logic       FRAME_ERR
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sck_sync, r_ss_sync, r_mosi_sync;
  logic                   r_sck_d, r_ss_d;
  logic [SYNC_STAGES:0]   r_sync_fill;
  logic                   w_sck, w_ss, w_mosi;
  logic                   w_sck_rise, w_ss_fall, w_ss_rise;
  logic                   w_start, w_shift_en, w_abort_err;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shreg;
  logic                   r_push;
  logic [7:0]             r_frame_bytes;
  logic                   r_frame_err;
  logic                   r_overrun;
  logic [7:0]             r_mem [FIFO_DEPTH];
  logic [AW:0]            r_wr_ptr, r_rd_ptr;
  logic                   w_empty, w_full, w_pop, w_wr_en;

  always_ff @(posedge MCU_CLK_25_000) begin
    if (RESET) begin
      r_sck_sync  <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_ss_d      <= 1'b1;
      r_sync_fill <= '0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SPI_SCK};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SPI_SS};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
      r_sck_d     <= w_sck;
      r_ss_d      <= w_ss;
      r_sync_fill <= {r_sync_fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_ss       = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_ss_rise  = w_ss & ~r_ss_d;
  // The reset-forced SS=1 in the chain must not look like a real high: a falling
  // edge only counts once both compared samples came from the pin after reset.
  assign w_ss_fall  = ~w_ss & r_ss_d & r_sync_fill[SYNC_STAGES];

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift_en  = 1'b0;
    w_abort_err = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ss_fall) begin
          w_state_nxt = SHIFT;
          w_start     = 1'b1;
        end
      end
      SHIFT: begin
        if (w_ss_rise) begin
          w_state_nxt = IDLE;
          w_abort_err = (r_bit_cnt != 3'd0);
        end else if (w_sck_rise) begin
          w_shift_en = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge MCU_CLK_25_000) begin
    if (RESET) begin
      r_state       <= IDLE;
      r_bit_cnt     <= 3'd0;
      r_shreg       <= 8'd0;
      r_push        <= 1'b0;
      r_frame_bytes <= 8'd0;
      r_frame_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_push      <= 1'b0;
      r_frame_err <= w_abort_err;
      if (w_start) begin
        r_bit_cnt     <= 3'd0;
        r_frame_bytes <= 8'd0;
      end
      if (w_shift_en) begin
        r_shreg   <= {r_shreg[6:0], w_mosi};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_push <= 1'b1;
          if (r_frame_bytes != 8'hFF) r_frame_bytes <= r_frame_bytes + 8'd1;
        end
      end
    end
  end

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = ~w_empty & RX_READY;
  // When full, a simultaneous pop frees the head slot that the write reuses.
  assign w_wr_en = r_push & (~w_full | w_pop);

  always_ff @(posedge MCU_CLK_25_000) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= r_shreg;
  end

  always_ff @(posedge MCU_CLK_25_000) begin
    if (RESET) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      if (r_push && w_full && !w_pop) r_overrun <= 1'b1;
    end
  end

  assign RX_VALID     = ~w_empty;
  assign RX_DATA      = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
  assign SAMPLE       = RX_DATA[7:4];
  assign FRAME_ACTIVE = (r_state == SHIFT);
  assign FRAME_BYTES  = r_frame_bytes;
  assign OVERRUN      = r_overrun;
  assign FRAME_ERR    = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_gps_spi_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gps_spi_rx : randomized scoreboard bench for gps_spi_rx.              |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_gps_spi_rx;
  localparam int FIFO_DEPTH  = 4;
  localparam int SYNC_STAGES = 2;

  logic       MCU_CLK_25_000 = 1'b0;
  logic       RESET    = 1'b1;
  logic       SPI_SCK  = 1'b0;
  logic       SPI_SS   = 1'b1;
  logic       SPI_MOSI = 1'b0;
  logic       RX_READY = 1'b1;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic [3:0] SAMPLE;
  logic       FRAME_ACTIVE;
  logic [7:0] FRAME_BYTES;
  logic       OVERRUN;
  logic       FRAME_ERR;

  gps_spi_rx #(.FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .MCU_CLK_25_000(MCU_CLK_25_000), .RESET(RESET), .SPI_SCK(SPI_SCK),
    .SPI_SS(SPI_SS), .SPI_MOSI(SPI_MOSI), .RX_READY(RX_READY),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .SAMPLE(SAMPLE),
    .FRAME_ACTIVE(FRAME_ACTIVE), .FRAME_BYTES(FRAME_BYTES),
    .OVERRUN(OVERRUN), .FRAME_ERR(FRAME_ERR)
  );

  always #20 MCU_CLK_25_000 = ~MCU_CLK_25_000;

  int         pass_cnt   = 0;
  int         total_cnt  = 0;
  int         err_pulses = 0;
  int         err_wide   = 0;
  bit         prev_err   = 1'b0;
  bit         rand_en    = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: every byte the DUT hands over is checked against the queue.
  always @(negedge MCU_CLK_25_000) begin
    if (!RESET && RX_VALID && RX_READY) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_byte: got 0x%0h, expected none", RX_DATA);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rx_data", {24'd0, RX_DATA}, {24'd0, mon_e});
        chk("sample", {28'd0, SAMPLE}, {28'd0, mon_e[7:4]});
      end
    end
    if (FRAME_ERR) begin
      err_pulses++;
      if (prev_err) err_wide++;
    end
    prev_err = FRAME_ERR;
  end

  always @(posedge MCU_CLK_25_000) begin
    if (rand_en) begin
      #5;
      if (rand_en) RX_READY = 1'($urandom_range(0, 1));
    end
  end

  task automatic wait_cyc(input int n, input int off);
    repeat (n) @(posedge MCU_CLK_25_000);
    #(off);
  endtask

  // Mode 0: MOSI changes while SCK is low, sampled on the rising edge, MSB first.
  task automatic send_bits(input logic [7:0] b, input int nbits, input int half,
                           input int off, input bit ready_at_push);
    for (int i = 7; i >= 8 - nbits; i--) begin
      SPI_MOSI = b[i];
      wait_cyc(half, off);
      SPI_SCK = 1'b1;
      if (ready_at_push && i == 0) begin
        // Two sync flops plus the edge register: the push lands in the cycle after the third edge.
        wait_cyc(3, 5);
        RX_READY = 1'b1;
        wait_cyc(half - 3, off);
      end else begin
        wait_cyc(half, off);
      end
      SPI_SCK = 1'b0;
    end
  endtask

  task automatic start_frame();
    SPI_SS = 1'b0;
    wait_cyc(4, 5);
  endtask

  task automatic end_frame();
    wait_cyc(4, 5);
    SPI_SS = 1'b1;
    wait_cyc(6, 5);
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    rand_en = 1'b0;
    wait_cyc(2, 8);
    RX_READY = 1'b1;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge MCU_CLK_25_000);
      if (exp_q.size() == 0 && !RX_VALID) done = 1'b1;
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    @(negedge MCU_CLK_25_000);
    chk({tag, "_rx_valid"},     {31'd0, RX_VALID},     32'd0);
    chk({tag, "_rx_data"},      {24'd0, RX_DATA},      32'd0);
    chk({tag, "_sample"},       {28'd0, SAMPLE},       32'd0);
    chk({tag, "_frame_active"}, {31'd0, FRAME_ACTIVE}, 32'd0);
    chk({tag, "_frame_bytes"},  {24'd0, FRAME_BYTES},  32'd0);
    chk({tag, "_overrun"},      {31'd0, OVERRUN},      32'd0);
    chk({tag, "_frame_err"},    {31'd0, FRAME_ERR},    32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] b5[5];
    int         len, half, occ;
    bit         exp_ovr;

    wait_cyc(5, 5);
    chk_reset_vals("reset");
    RESET = 1'b0;
    wait_cyc(8, 5);

    // Two-byte frame at 1 MHz SCK.
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    start_frame();
    send_bits(8'hA5, 8, 12, 5, 1'b0);
    send_bits(8'h3C, 8, 12, 5, 1'b0);
    end_frame();
    drain("basic_drain");
    chk("basic_frame_bytes", {24'd0, FRAME_BYTES}, 32'd2);
    chk("basic_err", err_pulses, 32'd0);
    chk("basic_overrun", {31'd0, OVERRUN}, 32'd0);
    chk("basic_active", {31'd0, FRAME_ACTIVE}, 32'd0);

    // Random frames, random SCK rate/phase, random consumer back-pressure.
    for (int f = 0; f < 6; f++) begin
      len  = $urandom_range(1, 6);
      half = $urandom_range(4, 10);
      rand_en = 1'b1;
      start_frame();
      for (int k = 0; k < len; k++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        send_bits(b, 8, half, $urandom_range(1, 35), 1'b0);
      end
      end_frame();
      drain("rand_drain");
      chk("rand_frame_bytes", {24'd0, FRAME_BYTES}, len);
    end
    chk("rand_overrun", {31'd0, OVERRUN}, 32'd0);
    chk("rand_err", err_pulses, 32'd0);

    // Overrun: consumer stalled, one byte more than the FIFO holds.
    RX_READY = 1'b0;
    occ = 0;
    exp_ovr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      b5[k] = 8'($urandom);
      if (occ < FIFO_DEPTH) begin
        exp_q.push_back(b5[k]);
        occ++;
      end else begin
        exp_ovr = 1'b1;
      end
    end
    start_frame();
    for (int k = 0; k < 5; k++) send_bits(b5[k], 8, 6, 5, 1'b0);
    end_frame();
    chk("ovr_valid", {31'd0, RX_VALID}, 32'd1);
    chk("ovr_head", {24'd0, RX_DATA}, {24'd0, b5[0]});
    chk("ovr_flag", {31'd0, OVERRUN}, {31'd0, exp_ovr});
    drain("ovr_drain");
    wait_cyc(5, 5);
    chk("ovr_sticky", {31'd0, OVERRUN}, 32'd1);

    // Frame error: SS raised after five bits.
    start_frame();
    send_bits(8'hFF, 5, 6, 5, 1'b0);
    end_frame();
    chk("ferr_pulses", err_pulses, 32'd1);
    chk("ferr_width", err_wide, 32'd0);
    chk("ferr_active", {31'd0, FRAME_ACTIVE}, 32'd0);
    chk("ferr_valid", {31'd0, RX_VALID}, 32'd0);
    chk("ferr_bytes", {24'd0, FRAME_BYTES}, 32'd0);

    // Reset mid-frame with SS still low: must stay idle until a fresh SS fall.
    start_frame();
    send_bits(8'hE0, 3, 6, 5, 1'b0);
    RESET = 1'b1;
    exp_q.delete();
    wait_cyc(3, 5);
    RESET = 1'b0;
    wait_cyc(6, 5);
    chk_reset_vals("midrst");
    SPI_SS = 1'b1;
    wait_cyc(6, 5);
    exp_q.push_back(8'h81);
    start_frame();
    send_bits(8'h81, 8, 6, 5, 1'b0);
    end_frame();
    drain("midrst_drain");
    chk("midrst_bytes", {24'd0, FRAME_BYTES}, 32'd1);
    chk("midrst_err", err_pulses, 32'd1);

    // Full FIFO with the consumer becoming ready exactly as the fifth byte is pushed.
    RX_READY = 1'b0;
    for (int k = 0; k < 5; k++) begin
      b5[k] = 8'($urandom);
      exp_q.push_back(b5[k]);
    end
    start_frame();
    for (int k = 0; k < 4; k++) send_bits(b5[k], 8, 6, 5, 1'b0);
    send_bits(b5[4], 8, 6, 5, 1'b1);
    end_frame();
    drain("fullpop_drain");
    chk("fullpop_overrun", {31'd0, OVERRUN}, 32'd0);
    chk("fullpop_bytes", {24'd0, FRAME_BYTES}, 32'd5);

    // Long frame: byte count saturates.
    start_frame();
    for (int k = 0; k < 300; k++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_bits(b, 8, 4, 5, 1'b0);
    end
    end_frame();
    drain("long_drain");
    chk("long_bytes", {24'd0, FRAME_BYTES}, 32'd255);
    chk("long_overrun", {31'd0, OVERRUN}, 32'd0);
    chk("long_err", err_pulses, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
`default_nettype wire
